mp_bus_master: RTL and testbench

MP_BUS_MASTER -- requirements
Module: mp_bus_master

---
 rtl/mp_bus_master.sv | 121 ++++++++++++
 tb/tb_mp_bus_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_bus_master.sv
// mp_bus_master: microprocessor-style bus master with read-back compare and cycle timeout
module mp_bus_master #(
    parameter logic [7:0] TIMEOUT = 8'hFF
) (
    input  logic        mp_clk,
    input  logic        sys_rst_l,
    input  logic        req_wr_l,
    input  logic        req_rd_l,
    input  logic        change_addx,
    input  logic        data_addx_rst_l,
    input  logic        sdram_busy_l,
    input  logic [15:0] mp_rd_data,
    output logic [19:0] mp_addx,
    output logic [15:0] mp_data,
    output logic        mp_cs_l,
    output logic        mp_wr_l,
    output logic        mp_rd_l,
    output logic [7:0]  state,
    output logic        data_ena,
    output logic        rd_err,
    output logic [7:0]  err_cnt,
    output logic        timeout
);
    typedef enum logic [7:0] {
        IDLE          = 8'h00,
        ASSERT        = 8'h01,
        ACK_WAIT      = 8'h02,
        DONE_WAIT     = 8'h03,
        DEASSERT_ADDX = 8'h04
    } state_t;

    state_t      cur, nxt;
    logic        is_wr, nxt_wr, active, waiting, expired, tmo_nxt, chk_nxt, mis;
    logic [7:0]  timer;
    logic [19:0] addr;
    logic [15:0] data;

    assign active   = cur inside {ASSERT, ACK_WAIT, DONE_WAIT};
    assign waiting  = cur inside {ACK_WAIT, DONE_WAIT};
    assign expired  = (timer + 8'd1) == TIMEOUT;
    assign mis      = chk_nxt && (mp_rd_data != data);
    assign mp_cs_l  = !active;
    assign mp_wr_l  = !(active && is_wr);
    assign mp_rd_l  = !(active && !is_wr);
    assign data_ena = active && is_wr;
    assign state    = cur;
    assign mp_addx  = addr;
    assign mp_data  = data;

    // next state, latched cycle type, timeout and compare decisions
    always_comb begin
        nxt     = cur;
        nxt_wr  = is_wr;
        tmo_nxt = 1'b0;
        chk_nxt = 1'b0;
        case (cur)
            IDLE: begin
                if (!req_wr_l) begin
                    nxt    = ASSERT;
                    nxt_wr = 1'b1;
                end else if (!req_rd_l) begin
                    nxt    = ASSERT;
                    nxt_wr = 1'b0;
                end
            end
            ASSERT: nxt = ACK_WAIT;
            ACK_WAIT: begin
                if (!sdram_busy_l) begin
                    nxt = DONE_WAIT;
                end else if (expired) begin
                    nxt     = DEASSERT_ADDX;
                    tmo_nxt = 1'b1;
                end
            end
            DONE_WAIT: begin
                if (sdram_busy_l) begin
                    nxt     = DEASSERT_ADDX;
                    chk_nxt = !is_wr;
                end else if (expired) begin
                    nxt     = DEASSERT_ADDX;
                    tmo_nxt = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // state, cycle type, wait timer and error reporting registers
    always_ff @(posedge mp_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            cur     <= IDLE;
            is_wr   <= 1'b0;
            timer   <= 8'h00;
            timeout <= 1'b0;
            rd_err  <= 1'b0;
            err_cnt <= 8'h00;
        end else begin
            cur     <= nxt;
            is_wr   <= nxt_wr;
            timer   <= (nxt == cur && waiting) ? timer + 8'd1 : 8'h00;
            timeout <= tmo_nxt;
            rd_err  <= mis;
            if (mis && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    // address/data counters: clear has priority, increments only in IDLE
    always_ff @(posedge mp_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            addr <= 20'h00000;
            data <= 16'h0000;
        end else if (!data_addx_rst_l) begin
            addr <= 20'h00000;
            data <= 16'h0000;
        end else if (change_addx && cur == IDLE) begin
            addr <= addr + 20'd1;
            data <= data + 16'd1;
        end
    end
endmodule

// File: tb/tb_mp_bus_master.sv
// tb_mp_bus_master: directed checks of bus cycles, counters, read compare, timeout and reset
module tb_mp_bus_master;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        req_wr_l = 1'b1;
    logic        req_rd_l = 1'b1;
    logic        change_addx = 1'b0;
    logic        dar_l = 1'b1;
    logic        busy_l = 1'b1;
    logic [15:0] rd_data = 16'h0000;
    logic [19:0] mp_addx;
    logic [15:0] mp_data;
    logic        mp_cs_l, mp_wr_l, mp_rd_l, data_ena, rd_err, timeout;
    logic [7:0]  state, err_cnt;
    logic [11:0] bus;
    int          total = 0;
    int          bad = 0;

    localparam logic [3:0] S_IDLE = 4'b1110;
    localparam logic [3:0] S_WR   = 4'b0011;
    localparam logic [3:0] S_RD   = 4'b0100;

    assign bus = {state, mp_cs_l, mp_wr_l, mp_rd_l, data_ena};

    always #5 clk = ~clk;

    mp_bus_master #(.TIMEOUT(8'h04)) dut (
        .mp_clk(clk),
        .sys_rst_l(rst_l),
        .req_wr_l(req_wr_l),
        .req_rd_l(req_rd_l),
        .change_addx(change_addx),
        .data_addx_rst_l(dar_l),
        .sdram_busy_l(busy_l),
        .mp_rd_data(rd_data),
        .mp_addx(mp_addx),
        .mp_data(mp_data),
        .mp_cs_l(mp_cs_l),
        .mp_wr_l(mp_wr_l),
        .mp_rd_l(mp_rd_l),
        .state(state),
        .data_ena(data_ena),
        .rd_err(rd_err),
        .err_cnt(err_cnt),
        .timeout(timeout)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_deassert(input logic wr_l, input logic rd_l);
        req_wr_l = wr_l;
        req_rd_l = rd_l;
        step();
        req_wr_l = 1'b1;
        req_rd_l = 1'b1;
        step();
        busy_l = 1'b0;
        step();
        busy_l = 1'b1;
        step();
    endtask

    task automatic test_reset;
        step();
        step();
        total++; if (bus !== {8'h00, S_IDLE}) begin bad++; $display("FAIL reset_bus got=%h exp=%h", bus, {8'h00, S_IDLE}); end
        total++; if ({mp_addx, mp_data} !== 36'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", {mp_addx, mp_data}); end
        total++; if ({err_cnt, rd_err, timeout} !== 10'h0) begin bad++; $display("FAIL reset_err got=%h exp=0", {err_cnt, rd_err, timeout}); end
        rst_l = 1'b1;
    endtask

    task automatic test_write;
        req_wr_l = 1'b0;
        step();
        total++; if (bus !== {8'h01, S_WR}) begin bad++; $display("FAIL wr_assert got=%h exp=%h", bus, {8'h01, S_WR}); end
        total++; if ({mp_addx, mp_data} !== 36'h0) begin bad++; $display("FAIL wr_addr_data got=%h exp=0", {mp_addx, mp_data}); end
        req_wr_l = 1'b1;
        step();
        total++; if (bus !== {8'h02, S_WR}) begin bad++; $display("FAIL wr_ack got=%h exp=%h", bus, {8'h02, S_WR}); end
        busy_l = 1'b0;
        step();
        total++; if (bus !== {8'h03, S_WR}) begin bad++; $display("FAIL wr_done1 got=%h exp=%h", bus, {8'h03, S_WR}); end
        step();
        total++; if (bus !== {8'h03, S_WR}) begin bad++; $display("FAIL wr_done2 got=%h exp=%h", bus, {8'h03, S_WR}); end
        busy_l = 1'b1;
        step();
        total++; if (bus !== {8'h04, S_IDLE}) begin bad++; $display("FAIL wr_deassert got=%h exp=%h", bus, {8'h04, S_IDLE}); end
        total++; if ({rd_err, timeout} !== 2'b00) begin bad++; $display("FAIL wr_flags got=%b exp=00", {rd_err, timeout}); end
        step();
        total++; if (bus !== {8'h00, S_IDLE}) begin bad++; $display("FAIL wr_idle got=%h exp=%h", bus, {8'h00, S_IDLE}); end
    endtask

    task automatic test_read;
        change_addx = 1'b1;
        repeat (5) step();
        change_addx = 1'b0;
        total++; if ({mp_addx, mp_data} !== {20'h00005, 16'h0005}) begin bad++; $display("FAIL rd_counters got=%h exp=%h", {mp_addx, mp_data}, {20'h00005, 16'h0005}); end
        rd_data = 16'h0005;
        req_rd_l = 1'b0;
        step();
        total++; if (bus !== {8'h01, S_RD}) begin bad++; $display("FAIL rd_assert got=%h exp=%h", bus, {8'h01, S_RD}); end
        req_rd_l = 1'b1;
        step();
        busy_l = 1'b0;
        step();
        busy_l = 1'b1;
        step();
        total++; if ({state, rd_err, err_cnt} !== {8'h04, 1'b0, 8'h00}) begin bad++; $display("FAIL rd_match got=%h exp=%h", {state, rd_err, err_cnt}, {8'h04, 1'b0, 8'h00}); end
        step();
        rd_data = 16'h0006;
        run_to_deassert(1'b1, 1'b0);
        total++; if ({state, rd_err, err_cnt} !== {8'h04, 1'b1, 8'h01}) begin bad++; $display("FAIL rd_mismatch got=%h exp=%h", {state, rd_err, err_cnt}, {8'h04, 1'b1, 8'h01}); end
        step();
        total++; if ({state, rd_err, err_cnt} !== {8'h00, 1'b0, 8'h01}) begin bad++; $display("FAIL rd_pulse_end got=%h exp=%h", {state, rd_err, err_cnt}, {8'h00, 1'b0, 8'h01}); end
    endtask

    task automatic test_wrap;
        force dut.addr = 20'hFFFFF;
        #1;
        release dut.addr;
        change_addx = 1'b1;
        step();
        change_addx = 1'b0;
        total++; if ({mp_addx, mp_data} !== {20'h00000, 16'h0006}) begin bad++; $display("FAIL wrap got=%h exp=%h", {mp_addx, mp_data}, {20'h00000, 16'h0006}); end
        req_wr_l = 1'b0;
        step();
        req_wr_l = 1'b1;
        step();
        busy_l = 1'b0;
        step();
        change_addx = 1'b1;
        step();
        change_addx = 1'b0;
        total++; if ({state, mp_addx, mp_data} !== {8'h03, 20'h00000, 16'h0006}) begin bad++; $display("FAIL wrap_busy_hold got=%h exp=%h", {state, mp_addx, mp_data}, {8'h03, 20'h00000, 16'h0006}); end
        busy_l = 1'b1;
        step();
        step();
        change_addx = 1'b1;
        step();
        change_addx = 1'b0;
        total++; if ({mp_addx, mp_data} !== {20'h00001, 16'h0007}) begin bad++; $display("FAIL incr got=%h exp=%h", {mp_addx, mp_data}, {20'h00001, 16'h0007}); end
        req_wr_l = 1'b0;
        step();
        req_wr_l = 1'b1;
        step();
        dar_l = 1'b0;
        change_addx = 1'b1;
        step();
        dar_l = 1'b1;
        change_addx = 1'b0;
        total++; if ({state, mp_addx, mp_data} !== {8'h02, 36'h0}) begin bad++; $display("FAIL clear got=%h exp=%h", {state, mp_addx, mp_data}, {8'h02, 36'h0}); end
        busy_l = 1'b0;
        step();
        busy_l = 1'b1;
        step();
        step();
    endtask

    task automatic test_timeout;
        rd_data = 16'hBEEF;
        req_rd_l = 1'b0;
        step();
        req_rd_l = 1'b1;
        step();
        total++; if (bus !== {8'h02, S_RD}) begin bad++; $display("FAIL tmo_ack got=%h exp=%h", bus, {8'h02, S_RD}); end
        repeat (3) step();
        total++; if ({state, timeout} !== {8'h02, 1'b0}) begin bad++; $display("FAIL tmo_ack_hold got=%h exp=%h", {state, timeout}, {8'h02, 1'b0}); end
        step();
        total++; if ({bus, timeout, rd_err, err_cnt} !== {8'h04, S_IDLE, 1'b1, 1'b0, 8'h01}) begin bad++; $display("FAIL tmo_ack_fire got=%h exp=%h", {bus, timeout, rd_err, err_cnt}, {8'h04, S_IDLE, 1'b1, 1'b0, 8'h01}); end
        step();
        total++; if ({state, timeout} !== {8'h00, 1'b0}) begin bad++; $display("FAIL tmo_idle got=%h exp=%h", {state, timeout}, {8'h00, 1'b0}); end
        req_rd_l = 1'b0;
        step();
        req_rd_l = 1'b1;
        step();
        busy_l = 1'b0;
        step();
        repeat (3) step();
        total++; if ({state, timeout} !== {8'h03, 1'b0}) begin bad++; $display("FAIL tmo_done_hold got=%h exp=%h", {state, timeout}, {8'h03, 1'b0}); end
        step();
        total++; if ({state, timeout, rd_err, err_cnt} !== {8'h04, 1'b1, 1'b0, 8'h01}) begin bad++; $display("FAIL tmo_done_fire got=%h exp=%h", {state, timeout, rd_err, err_cnt}, {8'h04, 1'b1, 1'b0, 8'h01}); end
        busy_l = 1'b1;
        step();
    endtask

    task automatic test_simultaneous;
        req_wr_l = 1'b0;
        req_rd_l = 1'b0;
        step();
        total++; if (bus !== {8'h01, S_WR}) begin bad++; $display("FAIL both_assert got=%h exp=%h", bus, {8'h01, S_WR}); end
        req_wr_l = 1'b1;
        req_rd_l = 1'b1;
        step();
        total++; if (bus !== {8'h02, S_WR}) begin bad++; $display("FAIL both_ack got=%h exp=%h", bus, {8'h02, S_WR}); end
        busy_l = 1'b0;
        step();
        busy_l = 1'b1;
        step();
        step();
        total++; if (bus !== {8'h00, S_IDLE}) begin bad++; $display("FAIL both_idle got=%h exp=%h", bus, {8'h00, S_IDLE}); end
    endtask

    task automatic test_reset_mid;
        rd_data = 16'h1234;
        req_rd_l = 1'b0;
        step();
        req_rd_l = 1'b1;
        step();
        busy_l = 1'b0;
        step();
        total++; if (bus !== {8'h03, S_RD}) begin bad++; $display("FAIL mid_done got=%h exp=%h", bus, {8'h03, S_RD}); end
        #2;
        rst_l = 1'b0;
        #1;
        total++; if ({bus, err_cnt, rd_err} !== {8'h00, S_IDLE, 8'h00, 1'b0}) begin bad++; $display("FAIL mid_reset got=%h exp=%h", {bus, err_cnt, rd_err}, {8'h00, S_IDLE, 8'h00, 1'b0}); end
        busy_l = 1'b1;
        step();
        rst_l = 1'b1;
        req_wr_l = 1'b0;
        step();
        total++; if (bus !== {8'h01, S_WR}) begin bad++; $display("FAIL first_req got=%h exp=%h", bus, {8'h01, S_WR}); end
        req_wr_l = 1'b1;
        step();
        busy_l = 1'b0;
        step();
        busy_l = 1'b1;
        step();
        step();
    endtask

    task automatic test_saturate;
        rd_data = 16'hFFFF;
        repeat (255) begin
            run_to_deassert(1'b1, 1'b0);
            step();
        end
        total++; if (err_cnt !== 8'hFF) begin bad++; $display("FAIL sat_reach got=%h exp=ff", err_cnt); end
        run_to_deassert(1'b1, 1'b0);
        total++; if ({rd_err, err_cnt} !== {1'b1, 8'hFF}) begin bad++; $display("FAIL sat_hold got=%h exp=%h", {rd_err, err_cnt}, {1'b1, 8'hFF}); end
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
